// File: rtl/sodor_internal_tile.sv
// Self-contained RV32I single-cycle tile: core, text ROM and data/stack RAM.
// Define SODOR_TRACE_EN to print a per-retirement PC/instruction/writeback trace.

module sodor_text_rom #(
    parameter logic [31:0] BASE  = 32'h80000000,
    parameter int unsigned WORDS = 500
) (
    input  logic [31:0] fetch_addr,
    input  logic [31:0] load_addr,
    output logic [31:0] fetch_data,
    output logic [31:0] load_data,
    output logic        load_hit
);
    localparam int AW = $clog2(WORDS * 4);

    logic [31:0] mem [0:WORDS-1];
    logic [31:0] fetch_off, load_off;

    assign fetch_off  = fetch_addr - BASE;
    assign load_off   = load_addr - BASE;
    assign load_hit   = load_off < WORDS * 4;
    // Fetches that leave the image execute as NOPs (addi x0,x0,0).
    assign fetch_data = (fetch_off < WORDS * 4) ? mem[fetch_off[AW-1:2]] : 32'h00000013;
    assign load_data  = load_hit ? mem[load_off[AW-1:2]] : 32'h0;
endmodule

module sodor_core #(
    parameter logic [31:0] TEXT_BASE = 32'h80000000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] io_imem_req_bits_addr,
    input  logic [31:0] io_imem_resp_bits_data,
    output logic [31:0] dmem_addr,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_wen,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata
);
    typedef enum logic [6:0] {
        OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
        OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_IMM = 7'h13,
        OP_REG = 7'h33, OP_SYSTEM = 7'h73
    } opcode_e;

    logic [31:0] pc, pc_next, pc_plus4, inst;
    logic [31:0] rf [0:31];
    logic [31:0] mepc, mtvec, mcause, mscratch;
    opcode_e     opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_val, rs2_val;
    logic [31:0] wb_data, csr_rdata, csr_src, csr_wdata, load_val;
    logic [15:0] lane;
    logic        wb_en, csr_wen, is_ecall, taken;

    assign inst     = io_imem_resp_bits_data;
    assign io_imem_req_bits_addr = pc;
    assign pc_plus4 = pc + 32'd4;
    assign opcode   = opcode_e'(inst[6:0]);
    assign rd       = inst[11:7];
    assign rs1      = inst[19:15];
    assign rs2      = inst[24:20];
    assign funct3   = inst[14:12];
    assign imm_i    = {{20{inst[31]}}, inst[31:20]};
    assign imm_s    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u    = {inst[31:12], 12'h000};
    assign imm_j    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign rs1_val  = (rs1 == 5'd0) ? 32'h0 : rf[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'h0 : rf[rs2];

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] sra;
        sra = $unsigned($signed(a) >>> b[4:0]);
        case (f3)
            3'd0:    alu = alt ? a - b : a + b;
            3'd1:    alu = a << b[4:0];
            3'd2:    alu = {31'h0, $signed(a) < $signed(b)};
            3'd3:    alu = {31'h0, a < b};
            3'd4:    alu = a ^ b;
            3'd5:    alu = alt ? sra : a >> b[4:0];
            3'd6:    alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    // Load path: little-endian lane picked by addr[1:0] within the addressed word.
    assign dmem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign lane      = 16'(dmem_rdata >> {dmem_addr[1:0], 3'b000});
    always_comb begin
        case (funct3)
            3'd0:    load_val = {{24{lane[7]}}, lane[7:0]};
            3'd1:    load_val = {{16{lane[15]}}, lane};
            3'd4:    load_val = {24'h0, lane[7:0]};
            3'd5:    load_val = {16'h0, lane};
            default: load_val = dmem_rdata;
        endcase
    end

    always_comb begin
        case (inst[31:20])
            12'h341: csr_rdata = mepc;
            12'h305: csr_rdata = mtvec;
            12'h342: csr_rdata = mcause;
            12'h340: csr_rdata = mscratch;
            default: csr_rdata = 32'h0;
        endcase
        csr_src = funct3[2] ? {27'h0, rs1} : rs1_val;
        case (funct3[1:0])
            2'd1:    csr_wdata = csr_src;
            2'd2:    csr_wdata = csr_rdata | csr_src;
            default: csr_wdata = csr_rdata & ~csr_src;
        endcase
        case (funct3)
            3'd0:    taken = rs1_val == rs2_val;
            3'd1:    taken = rs1_val != rs2_val;
            3'd4:    taken = $signed(rs1_val) < $signed(rs2_val);
            3'd5:    taken = $signed(rs1_val) >= $signed(rs2_val);
            3'd6:    taken = rs1_val < rs2_val;
            3'd7:    taken = rs1_val >= rs2_val;
            default: taken = 1'b0;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        pc_next    = pc_plus4;
        wb_en      = 1'b0;
        wb_data    = 32'h0;
        csr_wen    = 1'b0;
        is_ecall   = 1'b0;
        dmem_wen   = 1'b0;
        dmem_be    = 4'hf;
        dmem_wdata = rs2_val;
        case (opcode)
            OP_LUI:    begin wb_en = 1'b1; wb_data = imm_u; end
            OP_AUIPC:  begin wb_en = 1'b1; wb_data = pc + imm_u; end
            OP_JAL:    begin wb_en = 1'b1; wb_data = pc_plus4; pc_next = pc + imm_j; end
            OP_JALR:   begin wb_en = 1'b1; wb_data = pc_plus4; pc_next = (rs1_val + imm_i) & ~32'h1; end
            OP_BRANCH: if (taken) pc_next = pc + imm_b;
            OP_LOAD:   begin wb_en = 1'b1; wb_data = load_val; end
            OP_IMM:    begin wb_en = 1'b1; wb_data = alu(funct3, funct3 == 3'd5 && inst[30], rs1_val, imm_i); end
            OP_REG:    begin wb_en = 1'b1; wb_data = alu(funct3, inst[30], rs1_val, rs2_val); end
            OP_STORE: begin
                dmem_wen = reset;
                case (funct3[1:0])
                    2'd0: begin
                        dmem_be    = 4'b0001 << dmem_addr[1:0];
                        dmem_wdata = rs2_val << {dmem_addr[1:0], 3'b000};
                    end
                    2'd1: begin
                        dmem_be    = 4'b0011 << dmem_addr[1:0];
                        dmem_wdata = rs2_val << {dmem_addr[1:0], 3'b000};
                    end
                    default: ;
                endcase
            end
            OP_SYSTEM: begin
                if (funct3 != 3'd0) begin
                    wb_en = 1'b1; wb_data = csr_rdata; csr_wen = 1'b1;
                end else if (inst == 32'h00000073) begin
                    is_ecall = 1'b1; pc_next = mtvec;
                end else if (inst == 32'h30200073) begin
                    pc_next = mepc;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc       <= TEXT_BASE;
            mepc     <= 32'h0;
            mtvec    <= 32'h0;
            mcause   <= 32'h0;
            mscratch <= 32'h0;
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else begin
            pc <= {pc_next[31:2], 2'b00};
            if (wb_en && rd != 5'd0) rf[rd] <= wb_data;
            if (csr_wen) begin
                case (inst[31:20])
                    12'h341: mepc     <= csr_wdata;
                    12'h305: mtvec    <= csr_wdata;
                    12'h342: mcause   <= csr_wdata;
                    12'h340: mscratch <= csr_wdata;
                    default: ;
                endcase
            end
            if (is_ecall) begin
                mepc   <= pc;
                mcause <= 32'd11;
            end
        end
    end

`ifdef SODOR_TRACE_EN
    always @(posedge clock) begin
        if (reset) begin
            $display("PC=%h INST=%h", pc, inst);
            if (wb_en && rd != 5'd0) $display("x%0d<=%h", rd, wb_data);
        end
    end
`endif
endmodule

module sodor_internal_tile #(
    parameter logic [31:0] TEXT_BASE   = 32'h80000000,
    parameter int unsigned TEXT_WORDS  = 500,
    parameter logic [31:0] DATA_BASE   = 32'h80001000,
    parameter int unsigned DATA_BYTES  = 32'h300,
    parameter logic [31:0] STACK_BASE  = 32'h80021000,
    parameter int unsigned STACK_BYTES = 32'h200
) (
    input logic clock,
    input logic reset
);
    localparam int DATA_AW  = $clog2(DATA_BYTES);
    localparam int STACK_AW = $clog2(STACK_BYTES);

    logic [31:0] imem_addr, imem_data, dmem_addr, dmem_rdata, dmem_wdata;
    logic [31:0] text_rdata, data_off, stack_off;
    logic [3:0]  dmem_be;
    logic        dmem_wen, text_hit, data_hit, stack_hit;
    logic [31:0] data_mem  [0:DATA_BYTES/4-1];
    logic [31:0] stack_mem [0:STACK_BYTES/4-1];

    sodor_core #(.TEXT_BASE(TEXT_BASE)) core (
        .clock(clock), .reset(reset),
        .io_imem_req_bits_addr(imem_addr), .io_imem_resp_bits_data(imem_data),
        .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata), .dmem_wen(dmem_wen),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata)
    );

    sodor_text_rom #(.BASE(TEXT_BASE), .WORDS(TEXT_WORDS)) mem_text (
        .fetch_addr(imem_addr), .load_addr(dmem_addr),
        .fetch_data(imem_data), .load_data(text_rdata), .load_hit(text_hit)
    );

    assign data_off  = dmem_addr - DATA_BASE;
    assign stack_off = dmem_addr - STACK_BASE;
    assign data_hit  = data_off < DATA_BYTES;
    assign stack_hit = stack_off < STACK_BYTES;

    always_comb begin
        if (text_hit)       dmem_rdata = text_rdata;
        else if (data_hit)  dmem_rdata = data_mem[data_off[DATA_AW-1:2]];
        else if (stack_hit) dmem_rdata = stack_mem[stack_off[STACK_AW-1:2]];
        else                dmem_rdata = 32'h0;
    end

    // NOTE: RAM arrays have no reset branch; clearing them would turn block RAM into flops.
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (dmem_wen && dmem_be[b] && data_hit)
                data_mem[data_off[DATA_AW-1:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
            if (dmem_wen && dmem_be[b] && stack_hit)
                stack_mem[stack_off[STACK_AW-1:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_sodor_internal_tile.sv
// Directed-program bench for sodor_internal_tile: hand-assembled snippets poked into the
// text ROM, architectural state checked against hand-computed values.

module tb_sodor_internal_tile;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] prog[$];

    localparam logic [31:0] NOP = 32'h00000013;

    sodor_internal_tile dut (.clock(clock), .reset(reset));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'h37};
    endfunction

    task automatic li(input logic [4:0] rd, input logic [31:0] v);
        logic [31:0] hi;
        hi = (v + 32'h800) >> 12;
        prog.push_back(enc_lui(hi[19:0], rd));
        prog.push_back(enc_i(v[11:0], rd, 3'd0, rd, 7'h13));
    endtask

    task automatic load_prog();
        for (int i = 0; i < 500; i++) dut.mem_text.mem[i] = NOP;
        for (int i = 0; i < prog.size(); i++) dut.mem_text.mem[i] = prog[i];
        prog.delete();
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic restart();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        // Reset hold and straight-line fetch
        load_prog();
        for (int i = 0; i < 5; i++) begin
            step();
            check("reset_pc_hold", dut.core.io_imem_req_bits_addr, 32'h80000000);
        end
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("straight_pc", dut.core.io_imem_req_bits_addr, 32'h80000000 + 32'(4 * i));
        end

        // ALU
        li(5'd1, 32'hff00ff00);
        li(5'd2, 32'h0f0f0f0f);
        prog.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd3));         // and x3,x1,x2
        prog.push_back(enc_i(12'h001, 5'd0, 3'd0, 5'd5, 7'h13));     // addi x5,x0,1
        prog.push_back(enc_r(7'h20, 5'd5, 5'd0, 3'd0, 5'd4));         // sub x4,x0,x5
        prog.push_back(enc_i(12'h404, 5'd1, 3'd5, 5'd6, 7'h13));     // srai x6,x1,4
        prog.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd7));         // slt x7,x1,x2
        prog.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd8));         // sltu x8,x1,x2
        prog.push_back(enc_i(12'h01f, 5'd5, 3'd1, 5'd9, 7'h13));     // slli x9,x5,31
        prog.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd10));        // xor x10,x1,x2
        load_prog();
        restart();
        for (int i = 0; i < 12; i++) step();
        check("li_x1", dut.core.rf[1], 32'hff00ff00);
        check("li_x2", dut.core.rf[2], 32'h0f0f0f0f);
        check("and", dut.core.rf[3], 32'h0f000f00);
        check("sub_wrap", dut.core.rf[4], 32'hffffffff);
        check("srai", dut.core.rf[6], 32'hfff00ff0);
        check("slt", dut.core.rf[7], 32'h1);
        check("sltu", dut.core.rf[8], 32'h0);
        check("slli31", dut.core.rf[9], 32'h80000000);
        check("xor", dut.core.rf[10], 32'hf00ff00f);
        check("x0_zero", dut.core.rf[0], 32'h0);

        // Branches and jumps
        prog.push_back(enc_b(13'd8, 5'd0, 5'd0, 3'd0));               // 00 beq x0,x0,+8
        prog.push_back(enc_i(12'h001, 5'd0, 3'd0, 5'd10, 7'h13));    // 04 addi x10,x0,1
        prog.push_back(enc_i(12'h002, 5'd0, 3'd0, 5'd11, 7'h13));    // 08 addi x11,x0,2
        prog.push_back(32'hffffffff);                                 // 0c undecodable
        prog.push_back(enc_j(21'd16, 5'd1));                          // 10 jal x1,+16
        prog.push_back(enc_i(12'h005, 5'd0, 3'd0, 5'd12, 7'h13));    // 14 addi x12,x0,5
        prog.push_back(enc_b(13'd8, 5'd1, 5'd0, 3'd6));               // 18 bltu x0,x1,+8
        prog.push_back(NOP);                                          // 1c
        prog.push_back(enc_b(13'd8, 5'd0, 5'd0, 3'd1));               // 20 bne x0,x0,+8
        prog.push_back(enc_i(12'h005, 5'd1, 3'd0, 5'd13, 7'h67));    // 24 jalr x13,5(x1)
        load_prog();
        restart();
        step();
        check("beq_taken_pc", dut.core.io_imem_req_bits_addr, 32'h80000008);
        step();
        step();
        check("undecodable_pc", dut.core.io_imem_req_bits_addr, 32'h80000010);
        check("addi_after_beq", dut.core.rf[11], 32'h2);
        step();
        check("jal_pc", dut.core.io_imem_req_bits_addr, 32'h80000020);
        check("jal_link", dut.core.rf[1], 32'h80000014);
        step();
        check("bne_not_taken_pc", dut.core.io_imem_req_bits_addr, 32'h80000024);
        step();
        check("jalr_pc", dut.core.io_imem_req_bits_addr, 32'h80000018);
        check("jalr_link", dut.core.rf[13], 32'h80000028);
        step();
        check("bltu_taken_pc", dut.core.io_imem_req_bits_addr, 32'h80000020);
        check("beq_skipped", dut.core.rf[10], 32'h0);
        check("jal_skipped", dut.core.rf[12], 32'h0);

        // Loads and stores
        li(5'd1, 32'h12345678);
        prog.push_back(enc_lui(20'h80001, 5'd2));
        prog.push_back(enc_s(12'h000, 5'd1, 5'd2, 3'd2));             // sw x1,0(x2)
        prog.push_back(enc_i(12'h003, 5'd2, 3'd0, 5'd3, 7'h03));     // lb x3,3(x2)
        prog.push_back(enc_i(12'h000, 5'd2, 3'd4, 5'd4, 7'h03));     // lbu x4,0(x2)
        prog.push_back(enc_i(12'h002, 5'd2, 3'd1, 5'd5, 7'h03));     // lh x5,2(x2)
        prog.push_back(enc_i(12'h080, 5'd0, 3'd0, 5'd6, 7'h13));     // addi x6,x0,0x80
        prog.push_back(enc_s(12'h001, 5'd6, 5'd2, 3'd0));             // sb x6,1(x2)
        prog.push_back(enc_i(12'h001, 5'd2, 3'd0, 5'd7, 7'h03));     // lb x7,1(x2)
        prog.push_back(enc_i(12'h000, 5'd2, 3'd2, 5'd8, 7'h03));     // lw x8,0(x2)
        prog.push_back(enc_i(12'h000, 5'd2, 3'd5, 5'd14, 7'h03));    // lhu x14,0(x2)
        prog.push_back(enc_lui(20'h80021, 5'd9));
        prog.push_back(enc_s(12'h100, 5'd1, 5'd9, 3'd2));             // sw x1,0x100(x9)
        prog.push_back(enc_i(12'h100, 5'd9, 3'd2, 5'd10, 7'h03));    // lw x10,0x100(x9)
        prog.push_back(enc_lui(20'h80000, 5'd11));
        prog.push_back(enc_s(12'h100, 5'd1, 5'd11, 3'd2));            // sw x1,0x100(x11)
        prog.push_back(enc_i(12'h100, 5'd11, 3'd2, 5'd12, 7'h03));   // lw x12,0x100(x11)
        prog.push_back(enc_i(12'h007, 5'd0, 3'd0, 5'd13, 7'h13));    // addi x13,x0,7
        prog.push_back(enc_i(12'h000, 5'd0, 3'd2, 5'd13, 7'h03));    // lw x13,0(x0)
        load_prog();
        restart();
        for (int i = 0; i < 20; i++) step();
        check("lb_byte3", dut.core.rf[3], 32'h00000012);
        check("lbu_byte0", dut.core.rf[4], 32'h00000078);
        check("lh_half1", dut.core.rf[5], 32'h00001234);
        check("lb_sign", dut.core.rf[7], 32'hffffff80);
        check("sb_merge", dut.core.rf[8], 32'h12348078);
        check("lhu_zero_ext", dut.core.rf[14], 32'h00008078);
        check("stack_roundtrip", dut.core.rf[10], 32'h12345678);
        check("text_store_dropped", dut.core.rf[12], NOP);
        check("text_mem_intact", dut.mem_text.mem[64], NOP);
        check("unmapped_load", dut.core.rf[13], 32'h0);

        // CSRs and traps
        prog.push_back(enc_lui(20'h80000, 5'd1));
        prog.push_back(enc_i(12'h100, 5'd1, 3'd0, 5'd1, 7'h13));     // x1 = 0x80000100
        prog.push_back(enc_i(12'h305, 5'd1, 3'd1, 5'd0, 7'h73));     // csrw mtvec,x1
        prog.push_back(enc_i(12'h055, 5'd0, 3'd0, 5'd2, 7'h13));     // addi x2,x0,0x55
        prog.push_back(enc_i(12'h340, 5'd2, 3'd1, 5'd0, 7'h73));     // csrw mscratch,x2
        prog.push_back(enc_i(12'h340, 5'd0, 3'd2, 5'd3, 7'h73));     // csrr x3,mscratch
        prog.push_back(enc_i(12'h009, 5'd0, 3'd0, 5'd4, 7'h13));     // addi x4,x0,9
        prog.push_back(enc_i(12'hf14, 5'd0, 3'd2, 5'd4, 7'h73));     // csrr x4,mhartid
        prog.push_back(enc_i(12'hf14, 5'd2, 3'd1, 5'd0, 7'h73));     // csrw mhartid,x2
        prog.push_back(enc_i(12'h340, 5'd5, 3'd7, 5'd0, 7'h73));     // csrrci mscratch,5
        prog.push_back(enc_i(12'h340, 5'd2, 3'd6, 5'd7, 7'h73));     // csrrsi x7,mscratch,2
        while (prog.size() < 16) prog.push_back(NOP);
        prog.push_back(32'h00000073);                                 // 40 ecall
        load_prog();
        dut.mem_text.mem[64] = enc_i(12'h342, 5'd0, 3'd2, 5'd5, 7'h73);  // csrr x5,mcause
        dut.mem_text.mem[65] = enc_i(12'h341, 5'd0, 3'd2, 5'd6, 7'h73);  // csrr x6,mepc
        dut.mem_text.mem[66] = 32'h30200073;                              // mret
        restart();
        for (int i = 0; i < 16; i++) step();
        check("pc_at_ecall", dut.core.io_imem_req_bits_addr, 32'h80000040);
        check("csr_mscratch_read", dut.core.rf[3], 32'h55);
        check("mhartid_reads_zero", dut.core.rf[4], 32'h0);
        check("csrrsi_old_value", dut.core.rf[7], 32'h50);
        check("mscratch_final", dut.core.mscratch, 32'h52);
        check("mtvec", dut.core.mtvec, 32'h80000100);
        step();
        check("ecall_pc", dut.core.io_imem_req_bits_addr, 32'h80000100);
        check("ecall_mcause", dut.core.mcause, 32'd11);
        check("ecall_mepc", dut.core.mepc, 32'h80000040);
        step();
        step();
        step();
        check("mret_pc", dut.core.io_imem_req_bits_addr, 32'h80000040);
        check("csrr_mcause", dut.core.rf[5], 32'd11);
        check("csrr_mepc", dut.core.rf[6], 32'h80000040);

        // Reset mid-program
        reset = 1'b0;
        step();
        check("midreset_pc", dut.core.io_imem_req_bits_addr, 32'h80000000);
        check("midreset_x1", dut.core.rf[1], 32'h0);
        check("midreset_mtvec", dut.core.mtvec, 32'h0);
        reset = 1'b1;
        step();
        check("midreset_resume_pc", dut.core.io_imem_req_bits_addr, 32'h80000004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
